display_value_ctrl: RTL and testbench

- Controller that configures the 4-digit 7-segment display decoder from a binary value.
- Accepts a binary value through a valid/ready handshake and converts it to 4 BCD digits with a sequential double-dabble FSM.
- Applies leading-zero blanking and drives the decoder's digit codes and active-low anode mask.
- Sits between calculator result logic and the display decoder.

---
 rtl/display_value_ctrl.sv | 165 ++++++++++++++++
 tb/tb_display_value_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_value_ctrl.sv
// display_value_ctrl
//   Takes an unsigned binary value over a valid/ready handshake, converts it
//   to four BCD digits with a sequential double-dabble (one shift per clock),
//   applies leading-zero blanking and registers the digit codes and the
//   active-low anode mask for the 4-digit 7-segment decoder.
//   Values above MAX_VAL saturate to MAX_VAL and raise ovf.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   val_in/val_valid      value to display and its valid strobe
//   val_ready             high when a value can be accepted this cycle
//   clr                   synchronous clear back to the "0" display
//   busy                  conversion in progress (LOAD/SHIFT/COMMIT)
//   ovf                   last committed value exceeded MAX_VAL
//   an_out                active-low anode mask, bit0 = rightmost digit
//   dig_0_out..dig_3_out  digit codes 0-9, 8'hFF = blank (dig_0 = units)
//
// Optional feature: define DISP_BLINK_EN to blank the whole display
// periodically (every 2^(BLINK_W-1) cycles) while ovf is set.
module display_value_ctrl #(
  parameter int VAL_W   = 14,
  parameter int MAX_VAL = 9999,
  parameter int BLINK_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] val_in,
  input  logic             val_valid,
  output logic             val_ready,
  input  logic             clr,
  output logic             busy,
  output logic             ovf,
  output logic [3:0]       an_out,
  output logic [7:0]       dig_0_out,
  output logic [7:0]       dig_1_out,
  output logic [7:0]       dig_2_out,
  output logic [7:0]       dig_3_out
);

  localparam int CNT_W = $clog2(VAL_W + 1);
  localparam logic [VAL_W-1:0] MAX_V      = VAL_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(VAL_W - 1);

  if (VAL_W < 14 || BLINK_W < 1) begin : g_param_check
    $error("display_value_ctrl: VAL_W must be >= 14 and BLINK_W >= 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t           state;
  logic [VAL_W-1:0] val_q;
  logic [VAL_W-1:0] bin_q;
  logic [15:0]      bcd_q;
  logic [15:0]      bcd_adj;
  logic [CNT_W-1:0] shift_cnt;
  logic             ovf_int;
  logic             ovf_q;
  logic [3:0]       an_q;
  logic [7:0]       dig0_q, dig1_q, dig2_q, dig3_q;
  logic             blank3, blank2, blank1;

  assign val_ready = (state == IDLE) && !clr;
  assign busy      = (state != IDLE);
  assign ovf       = ovf_q;
  assign dig_0_out = dig0_q;
  assign dig_1_out = dig1_q;
  assign dig_2_out = dig2_q;
  assign dig_3_out = dig3_q;

  // Double-dabble correction: nibbles >= 5 get +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // A digit is blank only if it and every more significant digit are zero.
  always_comb begin
    blank3 = (bcd_q[15:12] == 4'd0);
    blank2 = blank3 && (bcd_q[11:8] == 4'd0);
    blank1 = blank2 && (bcd_q[7:4] == 4'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      val_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      shift_cnt <= '0;
      ovf_int   <= 1'b0;
      ovf_q     <= 1'b0;
      an_q      <= 4'b1110;
      dig0_q    <= 8'd0;
      dig1_q    <= '1;
      dig2_q    <= '1;
      dig3_q    <= '1;
    end else if (clr) begin
      state     <= IDLE;
      ovf_int   <= 1'b0;
      ovf_q     <= 1'b0;
      an_q      <= 4'b1110;
      dig0_q    <= 8'd0;
      dig1_q    <= '1;
      dig2_q    <= '1;
      dig3_q    <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (val_valid) begin
            val_q <= val_in;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (val_q > MAX_V) begin
            ovf_int <= 1'b1;
            bin_q   <= MAX_V;
          end else begin
            ovf_int <= 1'b0;
            bin_q   <= val_q;
          end
          bcd_q     <= '0;
          shift_cnt <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          shift_cnt      <= shift_cnt + 1'b1;
          if (shift_cnt == LAST_SHIFT) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          ovf_q  <= ovf_int;
          an_q   <= {blank3, blank2, blank1, 1'b0};
          dig3_q <= blank3 ? 8'hFF : {4'd0, bcd_q[15:12]};
          dig2_q <= blank2 ? 8'hFF : {4'd0, bcd_q[11:8]};
          dig1_q <= blank1 ? 8'hFF : {4'd0, bcd_q[7:4]};
          dig0_q <= {4'd0, bcd_q[3:0]};
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DISP_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_cnt <= '0;
    else       blink_cnt <= blink_cnt + 1'b1;
  end

  // Forcing is applied after the register so digit codes stay untouched.
  assign an_out = (ovf_q && blink_cnt[BLINK_W-1]) ? 4'b1111 : an_q;
`else
  assign an_out = an_q;
`endif

endmodule

// File: tb/tb_display_value_ctrl.sv
module tb_display_value_ctrl;
  localparam int VAL_W = 14;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [VAL_W-1:0] val_in = '0;
  logic             val_valid = 1'b0;
  logic             clr = 1'b0;
  logic             val_ready, busy, ovf;
  logic [3:0]       an_out;
  logic [7:0]       dig_0_out, dig_1_out, dig_2_out, dig_3_out;

  int checks = 0;
  int errors = 0;

  display_value_ctrl #(.VAL_W(VAL_W), .MAX_VAL(9999), .BLINK_W(4)) dut (
    .clk(clk), .reset(reset), .val_in(val_in), .val_valid(val_valid),
    .val_ready(val_ready), .clr(clr), .busy(busy), .ovf(ovf), .an_out(an_out),
    .dig_0_out(dig_0_out), .dig_1_out(dig_1_out), .dig_2_out(dig_2_out),
    .dig_3_out(dig_3_out)
  );

  always #5 clk = ~clk;

  // Expected display for a value: {dig3,dig2,dig1,dig0, an[3:0], ovf}.
  function automatic logic [36:0] model(input int unsigned v);
    int unsigned s;
    int unsigned d;
    bit lead;
    logic [36:0] r;
    s = (v > 9999) ? 9999 : v;
    r = '0;
    lead = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      d = (s / (10 ** k)) % 10;
      if (k == 0 || d != 0) lead = 1'b0;
      r[5 + 8*k +: 8] = lead ? 8'hFF : 8'(d);
      r[1 + k] = lead;
    end
    r[0] = (v > 9999);
    return r;
  endfunction

  function automatic logic [36:0] obs();
    logic [3:0] a;
    a = an_out;
`ifdef DISP_BLINK_EN
    if (ovf && an_out == 4'b1111) a = 4'b0000;
`endif
    return {dig_3_out, dig_2_out, dig_1_out, dig_0_out, a, ovf};
  endfunction

  // Returns #1 after the transfer edge.
  task automatic send(input int unsigned v);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    val_in = VAL_W'(v);
    val_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (val_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 val_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: value %0d not accepted, ready=%b required 1", v, val_ready);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(0) || busy !== 1'b0 || val_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got %h busy=%b ready=%b, required %h busy=0 ready=1",
               obs(), busy, val_ready, model(0));
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    send(1234);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== model(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got %h busy=%b, required %h busy=0", obs(), busy, model(0));
    end
    @(negedge clk) reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_commit: got %h busy=%b, required %h busy=0", obs(), busy, model(0));
    end
  endtask

  task automatic test_latency();
    send(1234);
    checks++;
    if (val_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_xfer: ready=%b busy=%b, required ready=0 busy=1", val_ready, busy);
    end
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(0) || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_before_commit: got %h busy=%b, required %h busy=1", obs(), busy, model(0));
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(1234) || busy !== 1'b0) begin
      errors++;
      $display("FAIL commit_1234: got %h busy=%b, required %h busy=0", obs(), busy, model(1234));
    end
  endtask

  task automatic test_blanking();
    int unsigned vals[3] = '{7, 0, 1005};
    foreach (vals[i]) begin
      send(vals[i]);
      repeat (16) @(posedge clk);
      #1;
      checks++;
      if (obs() !== model(vals[i])) begin
        errors++;
        $display("FAIL blank_%0d: got %h required %h", vals[i], obs(), model(vals[i]));
      end
    end
  endtask

  task automatic test_saturate();
    int n_on, n_off, n_bad;
    send(12000);
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(12000)) begin
      errors++;
      $display("FAIL saturate: got %h required %h", obs(), model(12000));
    end
    n_on = 0; n_off = 0; n_bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      if (an_out == 4'b0000) n_on++;
      else if (an_out == 4'b1111) n_off++;
      else n_bad++;
    end
    checks++;
`ifdef DISP_BLINK_EN
    if (n_bad != 0 || n_on != 16 || n_off != 16) begin
      errors++;
      $display("FAIL blink: on=%0d off=%0d other=%0d, required 16/16/0", n_on, n_off, n_bad);
    end
`else
    if (n_on != 32) begin
      errors++;
      $display("FAIL steady_mask: on=%0d off=%0d other=%0d, required 32/0/0", n_on, n_off, n_bad);
    end
`endif
  endtask

  task automatic test_clr();
    // clr together with val_valid: no transfer, saturated display cleared.
    @(negedge clk);
    clr = 1'b1;
    val_in = VAL_W'(42);
    val_valid = 1'b1;
    #1;
    checks++;
    if (val_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_ready: got %b required 0", val_ready);
    end
    @(posedge clk);
    #1;
    clr = 1'b0;
    val_valid = 1'b0;
    checks++;
    if (obs() !== model(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle: got %h busy=%b, required %h busy=0", obs(), busy, model(0));
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_no_xfer: got %h busy=%b, required %h busy=0", obs(), busy, model(0));
    end
    // clr in the middle of a conversion.
    send(9999);
    repeat (5) @(posedge clk);
    @(negedge clk) clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    checks++;
    if (obs() !== model(0) || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_abort: got %h busy=%b, required %h busy=0", obs(), busy, model(0));
    end
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(0)) begin
      errors++;
      $display("FAIL clr_abort_hold: got %h required %h", obs(), model(0));
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    send(300);
    @(negedge clk);
    val_in = VAL_W'(55);
    val_valid = 1'b1;
    edges = 1;
    while (!val_ready && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges != 17 || obs() !== model(300)) begin
      errors++;
      $display("FAIL b2b_accept: edge %0d shows %h, required edge 17 shows %h",
               edges, obs(), model(300));
    end
    @(posedge clk);
    #1 val_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(300) || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: got %h busy=%b, required %h busy=1", obs(), busy, model(300));
    end
    @(posedge clk);
    #1;
    checks++;
    if (obs() !== model(55)) begin
      errors++;
      $display("FAIL b2b_second: got %h required %h", obs(), model(55));
    end
  endtask

  task automatic test_random();
    int unsigned v;
    for (int i = 0; i < 12; i++) begin
      v = ($urandom_range(0, 3) == 0) ? $urandom_range(10000, 16383) : $urandom_range(0, 9999);
      send(v);
      repeat (16) @(posedge clk);
      #1;
      checks++;
      if (obs() !== model(v) || busy !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: got %h busy=%b, required %h busy=0", v, obs(), busy, model(v));
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_shift();
    test_latency();
    test_blanking();
    test_saturate();
    test_clr();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
